// File: rtl/mix_columns_seq_pkg.sv
// Shared AES definitions for the column-serial MixColumns stage:
// FSM encodings, state geometry and the GF(2^8) doubling helper.
package aes_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    localparam int AES_COLS    = 4;
    localparam int AES_STATE_W = 128;

    localparam logic [7:0] GF_POLY = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column; a0 sits in the top byte.
// Four doublings are shared: 3x is formed as 2x ^ x.
module mix_single_column
    import aes_defs::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);

    assign col_o[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
    assign col_o[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: load a state, mix one column per cycle,
// then hold the result until downstream takes it. Bypass skips mixing.
module mix_columns_seq
    import aes_defs::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    mc_state_e              state_q, state_d;
    logic [AES_STATE_W-1:0] data_q, data_d;
    logic [1:0]             col_q, col_d;
    logic                   byp_q, byp_d;

    logic [31:0] mix_in;
    logic [31:0] mix_out;

    always_comb begin
        mix_in = data_q[127:96];
        unique case (col_q)
            2'd0: mix_in = data_q[127:96];
            2'd1: mix_in = data_q[95:64];
            2'd2: mix_in = data_q[63:32];
            2'd3: mix_in = data_q[31:0];
            default: mix_in = data_q[127:96];
        endcase
    end

    mix_single_column u_mix (
        .col_i (mix_in),
        .col_o (mix_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        col_d   = col_q;
        byp_d   = byp_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    col_d   = 2'd0;
                    byp_d   = in_bypass;
                    state_d = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                unique case (col_q)
                    2'd0: data_d[127:96] = mix_out;
                    2'd1: data_d[95:64]  = mix_out;
                    2'd2: data_d[63:32]  = mix_out;
                    2'd3: data_d[31:0]   = mix_out;
                    default: data_d = data_q;
                endcase
                // col parks at 3; only a fresh load rewinds it
                if (col_q == 2'd3 || byp_q) begin
                    state_d = DONE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            col_q   <= 2'd0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            col_q   <= col_d;
            byp_q   <= byp_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule
